mux_word_serializer: RTL and testbench
======================================

Name: mux_word_serializer

Overview:
- Upstream sequencer for the 32:1 bit-select mux.
- Accepts a parallel word over a valid/ready handshake and holds it on the mux data bus.
- Steps the mux select through every lane, one lane per accepted output beat.
- Returns the selected mux output as a serial bit stream with its own valid/ready handshake, so the combinational mux becomes a flow-controlled parallel-to-serial converter.

Parameters:
- WIDTH, 32: word width and number of mux lanes. Must be a power of two, minimum 2.
- SEL_W, $clog2(WIDTH): width of the mux select. Derived; never overridden.
- MSB_FIRST, 0: 0 = lane 0 first (sel counts up); 1 = lane WIDTH-1 first (sel counts down).

Ports:
- clk  input  1  single clock. All state changes on the rising edge.
- rst_n  input  1  asynchronous assert, active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- mux_in  output  WIDTH  registered word driven onto the mux data bus.
- mux_sel  output  SEL_W  registered lane select driven to the mux.
- mux_out  input  1  combinational mux output: mux_in[mux_sel].
- ser_data  output  1  serial bit; equals mux_out in data beats.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  downstream accepts the bit.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - mux_in = 0, mux_sel = 0, bit count = 0.
  - ser_valid = 0, done = 0, parity accumulator = 0.
  - in_ready is decoded from state, so it reads 1 during and after reset.
- States: IDLE, SHIFT, and PAR (PAR exists only with the optional feature).
- IDLE:
  - in_ready = 1, ser_valid = 0.
  - On in_valid && in_ready: mux_in <= in_data; count <= 0; mux_sel <= MSB_FIRST ? WIDTH-1 : 0; go to SHIFT.
- SHIFT:
  - in_ready = 0, ser_valid = 1, ser_data = mux_out.
  - First valid bit appears the cycle after the input handshake (latency 1).
  - On ser_valid && ser_ready:
    - If count == WIDTH-1: go to IDLE (or PAR) and pulse done.
    - Otherwise: count += 1 and mux_sel steps by ±1.
- Backpressure: while ser_ready = 0, mux_in, mux_sel, count and ser_data stay stable and ser_valid stays 1.
- Throughput: one bit per cycle when ser_ready is held at 1. Exactly WIDTH beats per word; no data beat is ever skipped or repeated.
- Word-to-word gap: a new word is accepted only in IDLE. There is one idle cycle between the last beat of one word and the handshake of the next. in_valid asserted early is held off by in_ready = 0.
- Select wrap-around: mux_sel never wraps mid-word. The final beat is lane WIDTH-1 (up-count) or lane 0 (down-count). The select value after the final beat is don't-care until the next word loads.
- done: asserted exactly one cycle, in the cycle after the last beat handshake (after the parity beat when parity is enabled).
- Reset mid-word: the word is aborted immediately. ser_valid drops asynchronously, no done pulse is generated, and there is no partial resume.
- in_data changing while in SHIFT is ignored, because mux_in is registered.

Optional Feature:
- Macro: MUX_SER_PARITY_EN.
- Defined:
  - Each accepted data beat XORs mux_out into the parity accumulator; the accumulator clears on word load.
  - After the final data beat, the FSM enters PAR: ser_valid = 1, ser_data = accumulated even parity of the word.
  - The PAR beat obeys the same ser_ready backpressure rules.
  - On its handshake: go to IDLE and pulse done. Total WIDTH+1 beats per word.
- Undefined:
  - No PAR state and no accumulator logic.
  - Exactly WIDTH beats per word; done follows the final data beat.

Decomposition:
- Shared package mux_pkg:
  - state enum (IDLE, SHIFT, PAR).
  - MUX_WIDTH = 32 and MUX_SEL_W = 5 constants, reused by the mux and its benches.
- One natural sub-module, mux_sel_counter:
  - A loadable up/down counter with enable.
  - Produces mux_sel and a last-lane flag from MSB_FIRST and the bit count.
  - The FSM stays in the top.

Test Plan:
- Load 0x0000_0001 (LSB-first, ser_ready=1) -> beats: 1 then 31 zeros; mux_sel 0..31 on consecutive cycles; done 1 cycle after beat 31.
- Load 0xFFFF_FFFD -> beat 1 = 0, all other 31 beats = 1; in_ready = 0 for all 32 beats, 1 the cycle after.
- Load 0x4000_0000; hold ser_ready = 0 for 5 cycles at lane 30 -> ser_data = 1 and mux_sel = 30 stable throughout; resumes at lane 31 = 0.
- MSB_FIRST=1, load 0x8000_0000 -> first beat = 1 at mux_sel = 31, then 31 zeros down to mux_sel = 0.
- Assert rst_n low at beat 10 of 0xDFFF_FFFF -> ser_valid = 0 and mux_sel = 0 immediately; no done pulse; next word 0x0000_0004 serializes cleanly from lane 0.
- MUX_SER_PARITY_EN, load 0x0000_0007 -> 32 data beats then a parity beat = 1; load 0x0000_0003 -> parity beat = 0; done follows the parity beat.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the 32:1 bit-select mux and its
// serializer front end.
//   state_t    : serializer FSM states (PAR is only reachable when the
//                parity beat is compiled in).
//   MUX_WIDTH  : number of mux lanes / word width.
//   MUX_SEL_W  : width of the lane select.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam int MUX_WIDTH = 32;
    localparam int MUX_SEL_W = 5;

endpackage

// File: rtl/mux_sel_counter.sv
// mux_sel_counter: loadable up/down lane counter for the serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new word (bit count to 0, select to first lane)
//   step       : advance to the next lane (ignored on the last lane)
//   sel        : registered lane select for the mux
//   last       : the current lane is the final lane of the word
// The bit count, not the select, decides "last", so the same flag works
// for both traversal directions and the select never wraps mid-word.
module mux_sel_counter #(
    parameter int WIDTH     = 32,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    localparam logic [SEL_W-1:0] LANE_MAX = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sel   <= '0;
        end else if (load) begin
            count <= '0;
            sel   <= (MSB_FIRST != 0) ? LANE_MAX : '0;
        end else if (step && !last) begin
            count <= count + SEL_W'(1);
            sel   <= (MSB_FIRST != 0) ? sel - SEL_W'(1) : sel + SEL_W'(1);
        end
    end

    assign last = (count == LANE_MAX);

endmodule

// File: rtl/mux_word_serializer.sv
// mux_word_serializer: upstream sequencer for the WIDTH:1 bit-select mux.
// Captures a parallel word, drives it onto the mux data bus, walks the
// mux select through every lane and streams the selected bit out.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : parallel word input handshake
//   mux_in, mux_sel     : registered word and lane select to the mux
//   mux_out             : combinational mux output, mux_in[mux_sel]
//   ser_data/ser_valid/ser_ready : serial bit output handshake
//   done                : one-cycle pulse after the word's last beat
// Optional feature macro MUX_SER_PARITY_EN: appends one even-parity beat
// after the WIDTH data beats.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1; the sender holds data and valid stable
// until that edge, and valid never depends on ready.
module mux_word_serializer
    import mux_pkg::*;
#(
    parameter int WIDTH     = MUX_WIDTH,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             done
);

    state_t state_q, state_d;
    logic   load, step, done_d, last;

`ifdef MUX_SER_PARITY_EN
    logic   parity_q;
`endif

    mux_sel_counter #(
        .WIDTH     (WIDTH),
        .SEL_W     (SEL_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .sel   (mux_sel),
        .last  (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. ser_valid is 1 in SHIFT/PAR, so ser_ready alone
    // qualifies a beat there.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (last) begin
`ifdef MUX_SER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        step = 1'b1;
                    end
                end
            end
`ifdef MUX_SER_PARITY_EN
            ST_PAR: begin
                if (ser_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: in_ready and ser_valid follow the state directly, so
    // a reset drops ser_valid asynchronously.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        ser_valid = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`ifdef MUX_SER_PARITY_EN
        ser_data  = (state_q == ST_PAR) ? parity_q : mux_out;
`else
        ser_data  = mux_out;
`endif
    end

    // Word holding register and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_in <= '0;
            done   <= 1'b0;
        end else begin
            if (load) mux_in <= in_data;
            done <= done_d;
        end
    end

`ifdef MUX_SER_PARITY_EN
    // Even parity of the data beats actually accepted by downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= 1'b0;
        end else if (state_q == ST_SHIFT && ser_ready) begin
            parity_q <= parity_q ^ mux_out;
        end
    end
`endif

endmodule

// File: tb/tb_mux_word_serializer.sv
// tb_mux_word_serializer: directed bench for mux_word_serializer.
// Two instances: dut_a (LSB first) and dut_b (MSB first). The bench plays
// the mux itself. Each instance has a queue model of the bit stream it
// must produce; a per-instance compare process checks handshakes, data,
// lane select and done every cycle. Set MUX_SER_PARITY_EN to build the
// parity variant.
module tb_mux_word_serializer;
    import mux_pkg::*;

    localparam int W = MUX_WIDTH;
    localparam int SW = MUX_SEL_W;

    logic          clk, rst_n;
    logic [W-1:0]  in_data, mux_in;
    logic          in_valid, in_ready, mux_out, ser_data, ser_valid, ser_ready, done;
    logic [SW-1:0] mux_sel;
    logic [W-1:0]  b_in_data, b_mux_in;
    logic          b_in_valid, b_in_ready, b_mux_out, b_ser_data, b_ser_valid, b_ser_ready, b_done;
    logic [SW-1:0] b_mux_sel;

    int n_vec = 0;
    int n_err = 0;

    mux_word_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .done(done)
    );

    mux_word_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mux_in(b_mux_in), .mux_sel(b_mux_sel), .mux_out(b_mux_out),
        .ser_data(b_ser_data), .ser_valid(b_ser_valid), .ser_ready(b_ser_ready), .done(b_done)
    );

    // The 32:1 bit-select mux
    assign mux_out   = mux_in[mux_sel];
    assign b_mux_out = b_mux_in[b_mux_sel];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- models + compare ----------------
    logic [0:0] exp_q[$];
    int         lane_q[$];
    logic       done_pend_a;
    logic [0:0] b_exp_q[$];
    int         b_lane_q[$];
    logic       done_pend_b;

    always @(negedge clk) begin : cmp_a
        logic [0:0] e;
        int l;
        if (!rst_n) begin
            exp_q.delete();
            lane_q.delete();
            done_pend_a = 1'b0;
        end else begin
            chk("a_in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            chk("a_ser_valid", 32'(ser_valid), 32'(exp_q.size() != 0));
            chk("a_done", 32'(done), 32'(done_pend_a));
            done_pend_a = 1'b0;
            if (exp_q.size() != 0 && ser_ready) begin
                e = exp_q.pop_front();
                l = lane_q.pop_front();
                chk("a_ser_data", 32'(ser_data), 32'(e));
                if (l >= 0) chk("a_mux_sel", 32'(mux_sel), l);
                if (exp_q.size() == 0) done_pend_a = 1'b1;
            end else if (exp_q.size() == 0 && in_valid) begin
                for (int i = 0; i < W; i++) begin
                    exp_q.push_back(in_data[i]);
                    lane_q.push_back(i);
                end
`ifdef MUX_SER_PARITY_EN
                exp_q.push_back(^in_data);
                lane_q.push_back(-1);
`endif
            end
        end
    end

    always @(negedge clk) begin : cmp_b
        logic [0:0] e;
        int l;
        if (!rst_n) begin
            b_exp_q.delete();
            b_lane_q.delete();
            done_pend_b = 1'b0;
        end else begin
            chk("b_in_ready", 32'(b_in_ready), 32'(b_exp_q.size() == 0));
            chk("b_ser_valid", 32'(b_ser_valid), 32'(b_exp_q.size() != 0));
            chk("b_done", 32'(b_done), 32'(done_pend_b));
            done_pend_b = 1'b0;
            if (b_exp_q.size() != 0 && b_ser_ready) begin
                e = b_exp_q.pop_front();
                l = b_lane_q.pop_front();
                chk("b_ser_data", 32'(b_ser_data), 32'(e));
                if (l >= 0) chk("b_mux_sel", 32'(b_mux_sel), l);
                if (b_exp_q.size() == 0) done_pend_b = 1'b1;
            end else if (b_exp_q.size() == 0 && b_in_valid) begin
                for (int i = W - 1; i >= 0; i--) begin
                    b_exp_q.push_back(b_in_data[i]);
                    b_lane_q.push_back(i);
                end
`ifdef MUX_SER_PARITY_EN
                b_exp_q.push_back(^b_in_data);
                b_lane_q.push_back(-1);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Return #1 after the accepting edge, i.e. with beat 0 on the outputs.
    task automatic send_a(input logic [W-1:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) chk("a_send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_b(input logic [W-1:0] w);
        int t = 0;
        b_in_data  = w;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && t < 200) begin @(negedge clk); t++; end
        if (!b_in_ready) chk("b_send_timeout", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = $urandom;
    endtask

    task automatic wait_done_a();
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 200);
        if (!done) chk("a_done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_done_b();
        int t = 0;
        do begin @(negedge clk); t++; end while (!b_done && t < 200);
        if (!b_done) chk("b_done_timeout", 32'(b_done), 32'd1);
    endtask

    task automatic wait_sel_a(input logic [SW-1:0] s);
        int t = 0;
        do begin @(negedge clk); t++; end while (!(ser_valid && mux_sel == s) && t < 200);
        if (!(ser_valid && mux_sel == s)) chk("a_sel_timeout", 32'(mux_sel), 32'(s));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        ser_ready   = 1'b1;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_ser_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        chk("rst_mux_in", mux_in, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single one in lane 0
        send_a(32'h0000_0001);
        chk("w1_beat0_data", 32'(ser_data), 32'd1);
        chk("w1_beat0_sel", 32'(mux_sel), 32'd0);
        repeat (31) @(posedge clk);
        #1;
        chk("w1_beat31_sel", 32'(mux_sel), 32'd31);
        chk("w1_beat31_data", 32'(ser_data), 32'd0);
        wait_done_a();

        // single zero in lane 1, sent back-to-back
        send_a(32'hFFFF_FFFD);
        chk("w2_beat0_data", 32'(ser_data), 32'd1);
        @(posedge clk);
        #1;
        chk("w2_beat1_data", 32'(ser_data), 32'd0);
        chk("w2_in_ready", 32'(in_ready), 32'd0);
        wait_done_a();

        // backpressure on lane 30
        send_a(32'h4000_0000);
        wait_sel_a(SW'(29));
        @(posedge clk);
        #1 ser_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", 32'(ser_data), 32'd1);
            chk("bp_sel", 32'(mux_sel), 32'd30);
            chk("bp_valid", 32'(ser_valid), 32'd1);
        end
        @(posedge clk);
        #1 ser_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_resume_sel", 32'(mux_sel), 32'd31);
        chk("bp_resume_data", 32'(ser_data), 32'd0);
        wait_done_a();

        // MSB-first instance
        send_b(32'h8000_0000);
        chk("msb_beat0_data", 32'(b_ser_data), 32'd1);
        chk("msb_beat0_sel", 32'(b_mux_sel), 32'd31);
        @(posedge clk);
        #1;
        chk("msb_beat1_sel", 32'(b_mux_sel), 32'd30);
        chk("msb_beat1_data", 32'(b_ser_data), 32'd0);
        wait_done_b();

        // reset in the middle of a word
        send_a(32'hDFFF_FFFF);
        wait_sel_a(SW'(10));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ser_valid), 32'd0);
        chk("mid_rst_sel", 32'(mux_sel), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
        end
        send_a(32'h0000_0004);
        chk("w4_beat0_sel", 32'(mux_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("w4_beat2_data", 32'(ser_data), 32'd1);
        chk("w4_beat2_sel", 32'(mux_sel), 32'd2);
        wait_done_a();

`ifdef MUX_SER_PARITY_EN
        // parity beat: 0x7 has odd weight, 0x3 even
        send_a(32'h0000_0007);
        repeat (32) @(posedge clk);
        #1;
        chk("par7_beat", 32'(ser_data), 32'd1);
        chk("par7_valid", 32'(ser_valid), 32'd1);
        wait_done_a();
        send_a(32'h0000_0003);
        repeat (32) @(posedge clk);
        #1;
        chk("par3_beat", 32'(ser_data), 32'd0);
        wait_done_a();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
